// File: rtl/lcd_watch_time_cnt.sv
// Binary 24-hour timekeeper for the LCD watch: prescaled seconds counter with
// HH:MM:SS rollover and a small handshake FSM that validates and loads a new time.
module lcd_watch_time_cnt #(
  parameter int CNT_1S = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       SET_REQ,
  input  logic [6:0] SET_HOUR,
  input  logic [6:0] SET_MIN,
  input  logic [6:0] SET_SEC,
  output logic       SET_ACK,
  output logic       SET_ERR,
  output logic [6:0] HOUR,
  output logic [6:0] MIN,
  output logic [6:0] SEC,
  output logic       PM,
  output logic       SEC_TICK
);

  localparam int              PS_W   = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CNT_1S - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PS_W-1:0] ps;
  logic [6:0]      cap_hour;
  logic [6:0]      cap_min;
  logic [6:0]      cap_sec;
  logic            cap_valid;
  logic            check_valid;
  logic            capture_en;
  logic            load_en;
  logic            strobe;
  logic [6:0]      hour_next;
  logic [6:0]      min_next;
  logic [6:0]      sec_next;

  assign check_valid = (cap_hour <= 7'd23) && (cap_min <= 7'd59) && (cap_sec <= 7'd59);

  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        if (SET_REQ) begin
          capture_en = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        load_en    = check_valid;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A load in the same cycle as a due strobe swallows that strobe entirely.
  assign strobe = RUN && (ps == PS_MAX) && !load_en;

  always_comb begin
    hour_next = HOUR;
    min_next  = MIN;
    sec_next  = SEC;
    if (load_en) begin
      hour_next = cap_hour;
      min_next  = cap_min;
      sec_next  = cap_sec;
    end else if (strobe) begin
      if (SEC == 7'd59) begin
        sec_next = 7'd0;
        if (MIN == 7'd59) begin
          min_next  = 7'd0;
          hour_next = (HOUR == 7'd23) ? 7'd0 : HOUR + 7'd1;
        end else begin
          min_next = MIN + 7'd1;
        end
      end else begin
        sec_next = SEC + 7'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ps        <= '0;
      HOUR      <= 7'd0;
      MIN       <= 7'd0;
      SEC       <= 7'd0;
      PM        <= 1'b0;
      SEC_TICK  <= 1'b0;
      cap_hour  <= 7'd0;
      cap_min   <= 7'd0;
      cap_sec   <= 7'd0;
      cap_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (load_en) begin
        ps <= '0;
      end else if (RUN) begin
        ps <= (ps == PS_MAX) ? '0 : ps + PS_W'(1);
      end
      HOUR     <= hour_next;
      MIN      <= min_next;
      SEC      <= sec_next;
      PM       <= (hour_next >= 7'd12);
      SEC_TICK <= strobe;
      if (capture_en) begin
        cap_hour <= SET_HOUR;
        cap_min  <= SET_MIN;
        cap_sec  <= SET_SEC;
      end
      if (state == CHECK) begin
        cap_valid <= check_valid;
      end
    end
  end

  assign SET_ACK = (state == DONE) &&  cap_valid;
  assign SET_ERR = (state == DONE) && !cap_valid;

endmodule

// File: tb/tb_lcd_watch_time_cnt.sv
// Bench for lcd_watch_time_cnt with CNT_1S=4: table of load vectors plus
// hand-written sequences; load responses are matched against a scoreboard queue.
module tb_lcd_watch_time_cnt;

  localparam int CNT_1S = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       RUN;
  logic       SET_REQ;
  logic [6:0] SET_HOUR;
  logic [6:0] SET_MIN;
  logic [6:0] SET_SEC;
  logic       SET_ACK;
  logic       SET_ERR;
  logic [6:0] HOUR;
  logic [6:0] MIN;
  logic [6:0] SEC;
  logic       PM;
  logic       SEC_TICK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string name;
    int    ack;
    int    err;
    int    h;
    int    m;
    int    s;
    int    pm;
    int    due;
  } exp_t;

  typedef struct {
    string name;
    int    req_h, req_m, req_s;
    int    ack;
    int    h0, m0, s0, pm0;
    int    h1, m1, s1, pm1;
    int    h2, m2, s2, pm2;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];

  lcd_watch_time_cnt #(.CNT_1S(CNT_1S)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RUN      (RUN),
    .SET_REQ  (SET_REQ),
    .SET_HOUR (SET_HOUR),
    .SET_MIN  (SET_MIN),
    .SET_SEC  (SET_SEC),
    .SET_ACK  (SET_ACK),
    .SET_ERR  (SET_ERR),
    .HOUR     (HOUR),
    .MIN      (MIN),
    .SEC      (SEC),
    .PM       (PM),
    .SEC_TICK (SEC_TICK)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit run, input bit req,
                               input int h, input int m, input int s);
    RESET    = rst;
    RUN      = run;
    SET_REQ  = req;
    SET_HOUR = 7'(h);
    SET_MIN  = 7'(m);
    SET_SEC  = 7'(s);
    @(posedge CLK);
    #1;
  endtask

  task automatic expectLoad(input string name, input int ack, input int h, input int m,
                            input int s, input int pm);
    exp_t e;
    e.name = name;
    e.ack  = ack;
    e.err  = 1 - ack;
    e.h    = h;
    e.m    = m;
    e.s    = s;
    e.pm   = pm;
    e.due  = cyc + 2;
    sbq.push_back(e);
  endtask

  task automatic checkTime(input string name, input int h, input int m, input int s,
                           input int pm);
    checkOutput({name, "_hour"}, int'(HOUR), h);
    checkOutput({name, "_min"},  int'(MIN),  m);
    checkOutput({name, "_sec"},  int'(SEC),  s);
    checkOutput({name, "_pm"},   int'(PM),   pm);
  endtask

  task automatic checkAllZero(input string name);
    checkTime(name, 0, 0, 0, 0);
    checkOutput({name, "_tick"}, int'(SEC_TICK), 0);
    checkOutput({name, "_ack"},  int'(SET_ACK),  0);
    checkOutput({name, "_err"},  int'(SET_ERR),  0);
  endtask

  // Response monitor: every ACK/ERR pulse must match the oldest pending load.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (SET_ACK || SET_ERR) begin
        checkOutput("ack_err_exclusive", int'(SET_ACK & SET_ERR), 0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_resp ack=%0d err=%0d expected no response at cycle %0d",
                   SET_ACK, SET_ERR, cyc);
        end else begin
          e = sbq.pop_front();
          checkOutput({e.name, "_due"}, cyc, e.due);
          checkOutput({e.name, "_ack"}, int'(SET_ACK), e.ack);
          checkOutput({e.name, "_err"}, int'(SET_ERR), e.err);
          checkTime(e.name, e.h, e.m, e.s, e.pm);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL %s_timeout actual=no response expected=response at cycle %0d",
                 e.name, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET    = 1'b1;
    RUN      = 1'b0;
    SET_REQ  = 1'b0;
    SET_HOUR = 7'd0;
    SET_MIN  = 7'd0;
    SET_SEC  = 7'd0;

    vecs[0] = '{"load_235958", 23, 59, 58, 1, 23, 59, 58, 1, 23, 59, 59, 1, 0, 0, 0, 0};
    vecs[1] = '{"load_115959", 11, 59, 59, 1, 11, 59, 59, 0, 12, 0, 0, 1, 12, 0, 1, 1};
    vecs[2] = '{"bad_hour24",  24, 0, 0,   0, 12, 0, 1, 1,   12, 0, 2, 1, 12, 0, 3, 1};
    vecs[3] = '{"bad_min60",   5, 60, 0,   0, 12, 0, 3, 1,   12, 0, 4, 1, 12, 0, 5, 1};
    vecs[4] = '{"bad_sec60",   10, 20, 60, 0, 12, 0, 5, 1,   12, 0, 6, 1, 12, 0, 7, 1};
    vecs[5] = '{"load_005959", 0, 59, 59,  1, 0, 59, 59, 0,  1, 0, 0, 0,  1, 0, 1, 0};

    $display("[TB] start, CNT_1S=%0d", CNT_1S);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    checkAllZero("reset");

    // Free run from reset: ticks every CNT_1S cycles.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
      checkOutput($sformatf("run_tick_%0d", k), int'(SEC_TICK), int'(k % CNT_1S == 0));
      checkOutput($sformatf("run_sec_%0d", k), int'(SEC), k / CNT_1S);
    end
    checkOutput("run_hour", int'(HOUR), 0);
    checkOutput("run_pm", int'(PM), 0);

    // Table of loads with time frozen, then two seconds of running.
    for (int i = 0; i < 6; i++) begin
      expectLoad(vecs[i].name, vecs[i].ack, vecs[i].h0, vecs[i].m0, vecs[i].s0, vecs[i].pm0);
      applyStimulus(1'b0, 1'b0, 1'b1, vecs[i].req_h, vecs[i].req_m, vecs[i].req_s);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
      checkOutput({vecs[i].name, "_notick"}, int'(SEC_TICK), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
      for (int k = 1; k <= 2 * CNT_1S; k++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
        checkOutput($sformatf("%s_tick_%0d", vecs[i].name, k), int'(SEC_TICK),
                    int'(k % CNT_1S == 0));
        if (k == CNT_1S)
          checkTime({vecs[i].name, "_t1"}, vecs[i].h1, vecs[i].m1, vecs[i].s1, vecs[i].pm1);
      end
      checkTime({vecs[i].name, "_t2"}, vecs[i].h2, vecs[i].m2, vecs[i].s2, vecs[i].pm2);
    end

    // Load lands on the edge where a strobe is due; a second request in CHECK is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    expectLoad("collide", 1, 10, 30, 15, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10, 30, 15);
    checkOutput("collide_pre_sec", int'(SEC), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 2, 2);
    checkTime("collide_load", 10, 30, 15, 0);
    checkOutput("collide_load_tick", int'(SEC_TICK), 0);
    for (int k = 1; k <= CNT_1S; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
      checkOutput($sformatf("collide_tick_%0d", k), int'(SEC_TICK), int'(k == CNT_1S));
      checkOutput($sformatf("collide_sec_%0d", k), int'(SEC), (k == CNT_1S) ? 16 : 15);
    end
    checkOutput("collide_hour", int'(HOUR), 10);

    // Freeze mid-count: two cycles into a second, hold ten, then finish the second.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
      checkOutput($sformatf("hold_tick_%0d", k), int'(SEC_TICK), 0);
      checkOutput($sformatf("hold_sec_%0d", k), int'(SEC), 16);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    checkOutput("resume_tick_1", int'(SEC_TICK), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    checkOutput("resume_tick_2", int'(SEC_TICK), 1);
    checkTime("resume", 10, 30, 17, 0);

    // Reset while the FSM sits in CHECK: load aborted, no response pulse.
    applyStimulus(1'b0, 1'b0, 1'b1, 20, 20, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    checkAllZero("abort");
    for (int k = 1; k <= CNT_1S; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
      checkOutput($sformatf("post_rst_tick_%0d", k), int'(SEC_TICK), int'(k == CNT_1S));
      checkOutput($sformatf("post_rst_sec_%0d", k), int'(SEC), int'(k == CNT_1S));
      checkOutput($sformatf("post_rst_hour_%0d", k), int'(HOUR), 0);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
